// File: rtl/liang_pkg.sv
// Types shared between the fetch and decode stages of the in-order pipeline.
package liang_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } ifToId_t;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } ifu_state_e;

    localparam pc_t PC_STEP = 32'd4;

endpackage

// File: rtl/pipe_ifu.sv
// Instruction-fetch stage: one outstanding imem request, single-entry output buffer to decode.
// Optional performance counters are enabled with `define PIPE_IFU_PERF_CNT_EN.
module pipe_ifu
    import liang_pkg::*;
#(
    parameter pc_t RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  pc_t         flush_pc_i,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_req_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    output logic        if_valid_o,
    input  logic        id_ready_i,
    output ifToId_t     ifToId_o,
    output logic [63:0] perf_fetch_cnt_o,
    output logic [63:0] perf_stall_cnt_o
);

    ifu_state_e state_q, state_d;
    pc_t        pc_q, pc_d;
    logic       out_valid_q, out_valid_d;
    ifToId_t    out_q, out_d;

    logic req_valid;
    logic req_hs;
    logic id_xfer;

    assign req_valid = (state_q == S_REQ) && !out_valid_q;
    assign req_hs    = req_valid && imem_req_ready_i;
    assign id_xfer   = out_valid_q && id_ready_i;

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_q;
    assign if_valid_o       = out_valid_q;
    assign ifToId_o         = out_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;

        if (id_xfer) begin
            out_valid_d = 1'b0;
        end

        if (flush_i) begin
            // Redirect: any response seen this cycle is stale, and an accepted request is orphaned.
            pc_d        = flush_pc_i;
            out_valid_d = 1'b0;
            unique case (state_q)
                S_REQ:   state_d = req_hs ? S_DROP : S_REQ;
                S_WAIT:  state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
                S_DROP:  state_d = imem_rsp_valid_i ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (req_hs) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid_i) begin
                        out_d.pc    = pc_q;
                        out_d.inst  = imem_rsp_data_i;
                        out_valid_d = 1'b1;
                        pc_d        = pc_q + PC_STEP;
                        state_d     = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rsp_valid_i) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

`ifdef PIPE_IFU_PERF_CNT_EN
    logic [63:0] fetch_cnt_q;
    logic [63:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (id_xfer) begin
                fetch_cnt_q <= fetch_cnt_q + 64'd1;
            end
            if (state_q == S_WAIT) begin
                stall_cnt_q <= stall_cnt_q + 64'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`else
    assign perf_fetch_cnt_o = '0;
    assign perf_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_ifu.sv
// Self-checking bench for pipe_ifu: directed scenarios plus randomized traffic against a transaction-level model.
module tb_pipe_ifu;
    import liang_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    pc_t         flush_pc;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        if_valid;
    logic        id_ready;
    ifToId_t     if_pay;
    logic [63:0] perf_fetch;
    logic [63:0] perf_stall;

    logic        rst_w_n;
    logic        req_valid_w;
    logic        req_ready_w;
    logic [31:0] req_addr_w;
    logic        rsp_valid_w;
    logic [31:0] rsp_data_w;
    logic        if_valid_w;
    logic        id_ready_w;
    ifToId_t     if_pay_w;
    logic [63:0] perf_fetch_w;
    logic [63:0] perf_stall_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ifu dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .flush_i          (flush),
        .flush_pc_i       (flush_pc),
        .imem_req_valid_o (req_valid),
        .imem_req_ready_i (req_ready),
        .imem_req_addr_o  (req_addr),
        .imem_rsp_valid_i (rsp_valid),
        .imem_rsp_data_i  (rsp_data),
        .if_valid_o       (if_valid),
        .id_ready_i       (id_ready),
        .ifToId_o         (if_pay),
        .perf_fetch_cnt_o (perf_fetch),
        .perf_stall_cnt_o (perf_stall)
    );

    pipe_ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk_i            (clk),
        .rst_ni           (rst_w_n),
        .flush_i          (1'b0),
        .flush_pc_i       (32'h0),
        .imem_req_valid_o (req_valid_w),
        .imem_req_ready_i (req_ready_w),
        .imem_req_addr_o  (req_addr_w),
        .imem_rsp_valid_i (rsp_valid_w),
        .imem_rsp_data_i  (rsp_data_w),
        .if_valid_o       (if_valid_w),
        .id_ready_i       (id_ready_w),
        .ifToId_o         (if_pay_w),
        .perf_fetch_cnt_o (perf_fetch_w),
        .perf_stall_cnt_o (perf_stall_w)
    );

    // Transaction-level model: fetch PC, buffered instruction, and whether a
    // memory request is in flight and whether its answer is still wanted.
    logic [31:0] m_pc;
    bit          m_bv;
    logic [31:0] m_bpc;
    logic [31:0] m_binst;
    bit          m_out;
    bit          m_stale;
    logic [63:0] m_fetch;
    logic [63:0] m_stall;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h8000_0000;
        m_bv    = 0;
        m_bpc   = '0;
        m_binst = '0;
        m_out   = 0;
        m_stale = 0;
        m_fetch = '0;
        m_stall = '0;
    endtask

    task automatic compare_outputs();
        logic [63:0] exp_f, exp_s;
        check("req_valid", req_valid, !m_out && !m_bv);
        check("req_addr", req_addr, m_pc);
        check("if_valid", if_valid, m_bv);
        if (m_bv) check("payload", if_pay, {m_bpc, m_binst});
`ifdef PIPE_IFU_PERF_CNT_EN
        exp_f = m_fetch;
        exp_s = m_stall;
`else
        exp_f = '0;
        exp_s = '0;
`endif
        check("perf_fetch", perf_fetch, exp_f);
        check("perf_stall", perf_stall, exp_s);
    endtask

    task automatic model_update(input bit fl, input logic [31:0] fpc, input bit rdy,
                                input bit rsp, input logic [31:0] data, input bit idr);
        bit hs, xfer;
        hs   = !m_out && !m_bv && rdy;
        xfer = m_bv && idr;
        if (xfer) m_fetch = m_fetch + 1;
        if (m_out && !m_stale) m_stall = m_stall + 1;
        if (xfer) m_bv = 0;
        if (fl) begin
            m_pc = fpc;
            m_bv = 0;
            if (hs) begin
                m_out = 1; m_stale = 1;
            end else if (m_out && rsp) begin
                m_out = 0; m_stale = 0;
            end else if (m_out) begin
                m_stale = 1;
            end
        end else if (hs) begin
            m_out = 1; m_stale = 0;
        end else if (m_out && rsp) begin
            if (!m_stale) begin
                m_bpc = m_pc; m_binst = data; m_bv = 1; m_pc = m_pc + 32'd4;
            end
            m_out = 0; m_stale = 0;
        end
    endtask

    // Drive one cycle of inputs, compare, advance the model, move to just after the next edge.
    task automatic step(input bit fl, input logic [31:0] fpc, input bit rdy,
                        input bit rsp, input logic [31:0] data, input bit idr);
        flush = fl; flush_pc = fpc; req_ready = rdy;
        rsp_valid = rsp; rsp_data = data; id_ready = idr;
        compare_outputs();
        model_update(fl, fpc, rdy, rsp, data, idr);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 0; flush_pc = '0; req_ready = 0;
        rsp_valid = 0; rsp_data = '0; id_ready = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        model_reset();
    endtask

    initial begin
        bit          mem_pend;
        int          mem_cnt;
        bit          fl, rdy, rsp, idr, hs;
        logic [31:0] fpc, dat;

        rst_w_n = 0; req_ready_w = 0; rsp_valid_w = 0; rsp_data_w = '0; id_ready_w = 0;
        #1;
        do_reset();

        check("rst_req_valid", req_valid, 1'b1);
        check("rst_addr", req_addr, 32'h8000_0000);
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_payload", if_pay, 64'h0);
        check("rst_perf_fetch", perf_fetch, 64'h0);
        check("rst_perf_stall", perf_stall, 64'h0);

        // Zero-wait fetch of the first instruction.
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 32'h0000_0013, 1);
        check("first_valid", if_valid, 1'b1);
        check("first_payload", if_pay, {32'h8000_0000, 32'h0000_0013});
        step(0, 0, 0, 0, 0, 1);
        check("second_req_valid", req_valid, 1'b1);
        check("second_addr", req_addr, 32'h8000_0004);

        // Decode backpressure for five cycles.
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0010_0093, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", if_valid, 1'b1);
            check("bp_payload", if_pay, {32'h8000_0004, 32'h0010_0093});
            check("bp_req_valid", req_valid, 1'b0);
            step(0, 0, 1, 0, 0, 0);
        end
        step(0, 0, 1, 0, 0, 1);
        check("resume_req_valid", req_valid, 1'b1);
        check("resume_addr", req_addr, 32'h8000_0008);

        // Flush while waiting; the late response must be dropped.
        step(0, 0, 1, 0, 0, 1);
        step(1, 32'h8000_0100, 0, 0, 0, 1);
        check("drop_valid0", if_valid, 1'b0);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 1, 1, 32'hDEAD_BEEF, 1);
        check("drop_valid1", if_valid, 1'b0);
        check("redirect_req_valid", req_valid, 1'b1);
        check("redirect_addr", req_addr, 32'h8000_0100);

        // Flush coincident with the response.
        step(0, 0, 1, 0, 0, 1);
        step(1, 32'h8000_0200, 0, 1, 32'h0BAD_C0DE, 1);
        check("coinc_valid", if_valid, 1'b0);
        check("coinc_req_valid", req_valid, 1'b1);
        check("coinc_addr", req_addr, 32'h8000_0200);
        step(0, 0, 0, 0, 0, 1);
        check("coinc_never", if_valid, 1'b0);

        // Asynchronous reset mid-transaction.
        step(0, 0, 1, 0, 0, 1);
        rst_n = 0;
        #1;
        check("async_req_valid", req_valid, 1'b1);
        check("async_addr", req_addr, 32'h8000_0000);
        check("async_if_valid", if_valid, 1'b0);
        do_reset();

        // Ten instructions, two wait cycles each.
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 1, 0, 0, 1);
            step(0, 0, 1, 0, 0, 1);
            step(0, 0, 1, 1, 32'h1000_0000 + i, 1);
            step(0, 0, 0, 0, 0, 1);
        end
`ifdef PIPE_IFU_PERF_CNT_EN
        check("perf10_fetch", perf_fetch, 64'd10);
        check("perf10_stall", perf_stall, 64'd20);
`else
        check("perf10_fetch", perf_fetch, 64'd0);
        check("perf10_stall", perf_stall, 64'd0);
`endif
        check("perf10_addr", req_addr, 32'h8000_0028);

        // Randomized traffic with a variable-latency memory.
        do_reset();
        mem_pend = 0;
        mem_cnt  = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 1000 == 999) begin
                do_reset();
                mem_pend = 0;
            end
            rsp = mem_pend && (mem_cnt == 0);
            dat = $urandom;
            fl  = ($urandom_range(0, 15) == 0);
            fpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            rdy = ($urandom_range(0, 9) < 7);
            idr = ($urandom_range(0, 9) < 6);
            hs  = req_valid && rdy;
            step(fl, fpc, rdy, rsp, dat, idr);
            if (rsp) mem_pend = 0;
            if (hs) begin
                mem_pend = 1;
                mem_cnt  = $urandom_range(0, 3);
            end else if (mem_pend && mem_cnt > 0) begin
                mem_cnt--;
            end
        end

        // PC wraparound from the top of the address space.
        idle_inputs();
        rst_w_n = 1;
        check("wrap_first_addr", req_addr_w, 32'hFFFF_FFFC);
        req_ready_w = 1;
        id_ready_w  = 1;
        @(posedge clk); #1;
        req_ready_w = 0;
        rsp_valid_w = 1;
        rsp_data_w  = 32'h0000_0013;
        @(posedge clk); #1;
        rsp_valid_w = 0;
        check("wrap_payload", if_pay_w, {32'hFFFF_FFFC, 32'h0000_0013});
        @(posedge clk); #1;
        check("wrap_req_valid", req_valid_w, 1'b1);
        check("wrap_second_addr", req_addr_w, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
